// File: rtl/irq_request_ctrl_pkg.sv
// Shared constants and types for the interrupt request controller.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package irq_request_ctrl_pkg;

    // Default number of interrupt lines.
    localparam int N_IRQ_DEF    = 3;

    // Default debounce length in cycles; legal range 1..255.
    localparam int DEBOUNCE_DEF = 4;

    // Width of the debounce counter; sized for the largest legal DEBOUNCE.
    localparam int DEB_CNT_W    = 8;

    // Width of the accepted-event counter.
    localparam int EVT_CNT_W    = 16;

    typedef logic [DEB_CNT_W-1:0] deb_cnt_t;
    typedef logic [EVT_CNT_W-1:0] evt_cnt_t;

endpackage

// File: rtl/irq_request_ctrl_if.sv
// Bundle of the per-line interrupt signals between event sources/CPU and the controller.
// Latency: n/a (wires only).
// Backpressure: none; level/edge signalling only.
interface irq_request_ctrl_if
    import irq_request_ctrl_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF
) ();

    logic [N_IRQ-1:0] ext_evt;   // raw asynchronous event sources
    logic [N_IRQ-1:0] IRW;       // CPU in-service indication, rising edge = ack
    logic [N_IRQ-1:0] lost_clr;  // synchronous clear of the lost flags
    logic [N_IRQ-1:0] IRQ;       // registered level interrupt requests
    logic [N_IRQ-1:0] lost;      // sticky: event arrived while already pending
    evt_cnt_t         evt_cnt;   // accepted events, all lines, wrapping

    // Event sources / CPU side.
    modport master (
        output ext_evt,
        output IRW,
        output lost_clr,
        input  IRQ,
        input  lost,
        input  evt_cnt
    );

    // Controller side.
    modport slave (
        input  ext_evt,
        input  IRW,
        input  lost_clr,
        output IRQ,
        output lost,
        output evt_cnt
    );

endinterface

// File: rtl/irq_line_filter.sv
// One interrupt line: 2-flop synchronizer, debounce filter, rising-edge pulse.
// Latency: 2 sync + DEBOUNCE filter cycles from first sampling edge to evt pulse.
// Backpressure: none; evt is a one-cycle pulse that must be consumed immediately.
module irq_line_filter
    import irq_request_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_evt,
    output logic evt
);

    localparam deb_cnt_t CNT_LAST = deb_cnt_t'(DEBOUNCE - 1);

    logic     s1;
    logic     s2;
    logic     filt;
    deb_cnt_t cnt;
    logic     flip;

    // The filtered level flips once the mismatch has persisted DEBOUNCE cycles.
    assign flip = (s2 != filt) && (cnt == CNT_LAST);

    // Two-flop synchronizer for the asynchronous event source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ext_evt;
            s2 <= s1;
        end
    end

    // Debounce: count mismatching cycles, restart on any match, toggle on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (s2 == filt) begin
            cnt  <= '0;
        end else if (flip) begin
            filt <= ~filt;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + deb_cnt_t'(1);
        end
    end

    // Pulse in the same cycle filt becomes 1; falling transitions are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt <= 1'b0;
        end else begin
            evt <= flip & ~filt;
        end
    end

endmodule

// File: rtl/irq_request_ctrl.sv
// Interrupt request controller: per-line filtered events become pending IRQ levels until acked.
// Latency: 2+DEBOUNCE+1 cycles from first edge sampling a stable high event to IRQ=1.
// Backpressure: none; events arriving while pending are dropped and flagged in lost.
module irq_request_ctrl
    import irq_request_ctrl_pkg::*;
#(
    parameter int N_IRQ    = N_IRQ_DEF,
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    irq_request_ctrl_if.slave  bus
);

    logic [N_IRQ-1:0] evt;
    logic [N_IRQ-1:0] irw_q;
    logic [N_IRQ-1:0] ack;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] lost_q;
    logic [N_IRQ-1:0] lost_evt;
    evt_cnt_t         cnt_q;
    evt_cnt_t         cnt_inc;

    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
        irq_line_filter #(
            .DEBOUNCE (DEBOUNCE)
        ) u_filter (
            .clk     (clk),
            .rst     (rst),
            .ext_evt (bus.ext_evt[gi]),
            .evt     (evt[gi])
        );
    end

    // Only the rising edge of the in-service flag acknowledges; a held level does nothing.
    assign ack      = bus.IRW & ~irw_q;

    // An event is lost when the line is still pending and not being acked this cycle.
    assign lost_evt = evt & pending & ~ack;

    // Number of accepted (not lost) events this cycle, summed across lines.
    always_comb begin
        cnt_inc = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (evt[i] && !lost_evt[i]) begin
                cnt_inc = cnt_inc + evt_cnt_t'(1);
            end
        end
    end

    // Remember the previous in-service level for ack edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irw_q <= '0;
        end else begin
            irw_q <= bus.IRW;
        end
    end

    // Pending: a new event wins over a coincident ack so the request is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (evt[i]) begin
                    pending[i] <= 1'b1;
                end else if (ack[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky lost flags; a new loss wins over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_q <= '0;
        end else begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (lost_evt[i]) begin
                    lost_q[i] <= 1'b1;
                end else if (bus.lost_clr[i]) begin
                    lost_q[i] <= 1'b0;
                end
            end
        end
    end

    // Accepted-event counter, wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + cnt_inc;
        end
    end

    assign bus.IRQ     = pending;
    assign bus.lost    = lost_q;
    assign bus.evt_cnt = cnt_q;

endmodule

// File: doc/irq_request_ctrl.md
IRQ_REQUEST_CTRL -- requirements
Module: irq_request_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 3: number of interrupt lines.
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive stable cycles required before a filtered level changes; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ext_evt, input, N_IRQ: asynchronous raw event sources, e.g. buttons, one per line.
REQ-006 SHALL have port IRW, input, N_IRQ: CPU in-service indication; a rising edge on IRW[i] acknowledges line i.
REQ-007 SHALL have port lost_clr, input, N_IRQ: synchronous clear of lost[i].
REQ-008 SHALL have port IRQ, output, N_IRQ: level interrupt requests to the CPU, registered.
REQ-009 SHALL have port lost, output, N_IRQ: sticky flag; an event arrived while line i was already pending.
REQ-010 SHALL have port evt_cnt, output, 16: count of accepted events, all lines, wraps 0xFFFF->0x0000.

Function
REQ-011 SHALL pass each ext_evt[i] through a two-flop synchronizer; only the second stage s2[i] is used further.
REQ-012 SHALL keep per line a filtered level filt[i] and a counter that counts cycles with s2[i]!=filt[i], resetting to 0 whenever s2[i]==filt[i].
REQ-013 SHALL toggle filt[i] and clear the counter in the cycle the counter reaches DEBOUNCE-1 while s2[i]!=filt[i]; glitches shorter than DEBOUNCE cycles SHALL never change filt[i].
REQ-014 SHALL generate evt[i], a one-cycle pulse, on a 0->1 transition of filt[i] only; 1->0 transitions generate nothing.
REQ-015 SHALL register IRW as irw_q and define ack[i] = IRW[i] & ~irw_q[i].
REQ-016 SHALL update pending[i] by priority: evt[i] -> 1; else ack[i] -> 0; else hold (an event coincident with an ack keeps the line pending).
REQ-017 SHALL drive IRQ[i] directly from pending[i]; no combinational path from any input to IRQ.
REQ-018 SHALL give a latency of 2+DEBOUNCE+1 cycles from the first clock edge sampling a stable high ext_evt[i] to IRQ[i]=1.
REQ-019 SHALL deassert IRQ[i] on the clock edge after the edge on which the IRW[i] rising edge is sampled, absent a new evt[i].
REQ-020 SHALL set lost[i] when evt[i]=1, pending[i]=1 and ack[i]=0; lost_clr[i] SHALL clear it, with set winning over a coincident clear.
REQ-021 SHALL increment evt_cnt once per cycle by the number of lines with evt[i]=1 that are not lost, so simultaneous events add up to N_IRQ in one cycle.
REQ-022 SHALL treat IRW[i] held high as no further ack; a new event during service re-asserts IRQ[i], cleared only by the next IRW[i] rising edge.
REQ-023 SHALL keep lines fully independent; no priority encoding, which is the CPU's job.

Reset
REQ-024 SHALL, while rst=1, force synchronizers, filt, counters, irw_q, pending, lost and evt_cnt to 0, so IRQ=0, lost=0 and evt_cnt=0.
REQ-025 SHALL, on reset assertion mid-debounce or mid-service, drop all in-flight events; after release, an ext_evt already high SHALL be treated as a new rising event and raise IRQ after REQ-018 latency.

Structure
REQ-026 SHALL place N_IRQ default, the DEBOUNCE default and the evt_cnt width constant in the shared CPU package used by cpu.
REQ-027 SHALL implement the synchronizer, debounce and edge detect of one line as sub-module irq_line_filter, instantiated N_IRQ times; pending, lost and count logic SHALL stay in the top.

Verification
REQ-028 SHALL cover: ext_evt[0] high from cycle 0, DEBOUNCE=4 -> IRQ[0]=1 at cycle 7, evt_cnt=1.
REQ-029 SHALL cover: ext_evt[1] 3-cycle glitch, DEBOUNCE=4 -> IRQ[1] stays 0, evt_cnt unchanged.
REQ-030 SHALL cover: IRQ[2]=1, then IRW[2] 0->1 -> IRQ[2]=0 next cycle; IRW[2] held high 20 cycles -> no further change.
REQ-031 SHALL cover: second debounced event on line 0 while pending, no ack -> lost[0]=1, evt_cnt unchanged; lost_clr[0] pulse -> lost[0]=0.
REQ-032 SHALL cover: evt[1] and ack[1] in the same cycle -> IRQ[1] stays 1; simultaneous events on all 3 lines -> evt_cnt +3 in one cycle.
REQ-033 SHALL cover: rst pulsed while IRQ=3'b101 and ext_evt[0] high -> IRQ=0, evt_cnt=0 immediately; IRQ[0] returns 4+DEBOUNCE-1 cycles after release.
